// File: rtl/spi_top_f.sv
// SPI subsystem: one mode-0, MSB-first master driving two internal slave shift registers.
// Bus pins are exported purely for observation; everything runs on a single clock.
module spi_top_f #(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       SCLK_HALF   = 1,
    parameter logic [DATA_W-1:0] MASTER_INIT = 8'hA5,
    parameter logic [DATA_W-1:0] SLV1_INIT   = 8'h3C,
    parameter logic [DATA_W-1:0] SLV2_INIT   = 8'hC3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] dtf,
    input  logic [1:0] slave,
    output logic       sclk,
    output logic       mosi,
    output logic       miso,
    output logic       ssb1,
    output logic       ssb2
);

    localparam int unsigned CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_W - 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_HALF - 1);

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StGap
    } state_e;

    state_e            state_q;
    logic [1:0]        sel_q;
    logic              mode_q;
    logic [CW-1:0]     bcnt_q;
    logic [HW-1:0]     hcnt_q;
    logic              sclk_q;
    logic              ssb1_q;
    logic              ssb2_q;
    logic              msmp_q;
    logic              ssmp_q;
    logic [DATA_W-1:0] mreg_q;
    logic [DATA_W-1:0] s1_q;
    logic [DATA_W-1:0] s2_q;

    logic start;
    logic xfer;
    logic slv_msb;

    assign start = dtf[1] && (slave == 2'b01 || slave == 2'b10);
    assign xfer  = (state_q == StXfer);

    always_comb begin
        slv_msb = 1'b0;
        if (sel_q == 2'b01) begin
            slv_msb = s1_q[DATA_W-1];
        end else if (sel_q == 2'b10) begin
            slv_msb = s2_q[DATA_W-1];
        end
    end

    // Data pins are forced low outside XFER so GAP/IDLE show a quiet bus.
    assign mosi = xfer & mreg_q[DATA_W-1];
    assign miso = xfer & slv_msb;
    assign sclk = sclk_q;
    assign ssb1 = ssb1_q;
    assign ssb2 = ssb2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            sel_q   <= 2'b00;
            mode_q  <= 1'b0;
            bcnt_q  <= '0;
            hcnt_q  <= '0;
            sclk_q  <= 1'b0;
            ssb1_q  <= 1'b1;
            ssb2_q  <= 1'b1;
            msmp_q  <= 1'b0;
            ssmp_q  <= 1'b0;
            mreg_q  <= MASTER_INIT;
            s1_q    <= SLV1_INIT;
            s2_q    <= SLV2_INIT;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StXfer;
                        sel_q   <= slave;
                        mode_q  <= dtf[0];
                        bcnt_q  <= '0;
                        hcnt_q  <= '0;
                        sclk_q  <= 1'b0;
                        ssb1_q  <= (slave != 2'b01);
                        ssb2_q  <= (slave != 2'b10);
                    end
                end
                StXfer: begin
                    if (hcnt_q == HALF_LAST) begin
                        hcnt_q <= '0;
                        if (!sclk_q) begin
                            // Rising sclk: both ends sample the opposite pin.
                            sclk_q <= 1'b1;
                            msmp_q <= miso;
                            ssmp_q <= mosi;
                        end else begin
                            // Falling sclk: shift; write mode recirculates the master MSB.
                            sclk_q <= 1'b0;
                            mreg_q <= {mreg_q[DATA_W-2:0], mode_q ? msmp_q : mreg_q[DATA_W-1]};
                            if (sel_q == 2'b01) begin
                                s1_q <= {s1_q[DATA_W-2:0], ssmp_q};
                            end else begin
                                s2_q <= {s2_q[DATA_W-2:0], ssmp_q};
                            end
                            bcnt_q <= bcnt_q + CW'(1);
                            if (bcnt_q == BIT_LAST) begin
                                state_q <= StGap;
                                ssb1_q  <= 1'b1;
                                ssb2_q  <= 1'b1;
                            end
                        end
                    end else begin
                        hcnt_q <= hcnt_q + HW'(1);
                    end
                end
                StGap: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_top_f.sv
// Directed bench for spi_top_f: a vector table of single transfers plus hand-written
// sequences for mid-transfer select changes, back-to-back gap timing and reset abort.
module tb_spi_top_f;

    logic       clk;
    logic       rst;
    logic [1:0] dtf;
    logic [1:0] slave;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       ssb1;
    logic       ssb2;

    int total = 0;
    int bad   = 0;

    spi_top_f dut (
        .clk   (clk),
        .rst   (rst),
        .dtf   (dtf),
        .slave (slave),
        .sclk  (sclk),
        .mosi  (mosi),
        .miso  (miso),
        .ssb1  (ssb1),
        .ssb2  (ssb2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0] dtf;
        logic [1:0] slave;
        logic       act;
        logic [7:0] exp_mosi;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Waits (bounded) for a select to drop, then records one transfer at negedges.
    task automatic measure(input int switch_at, input logic [1:0] new_slave, input bit drop,
                           output logic [7:0] mo, output logic [7:0] mi, output int l1,
                           output int l2, output int rises, output int waited);
        logic prev;
        int   n;
        mo = 8'h00; mi = 8'h00; l1 = 0; l2 = 0; rises = 0; waited = 0; prev = 1'b0; n = 0;
        while (waited < 20) begin
            @(negedge clk);
            if (!ssb1 || !ssb2) break;
            waited++;
        end
        if (waited < 20) begin
            if (drop) dtf = 2'b00;
            for (int k = 0; k < 60; k++) begin
                if (!ssb1) l1++;
                if (!ssb2) l2++;
                if (sclk && !prev) begin
                    rises++;
                    mo = {mo[6:0], mosi};
                    mi = {mi[6:0], miso};
                end
                prev = sclk;
                n++;
                if (n == switch_at) slave = new_slave;
                @(negedge clk);
                if (ssb1 && ssb2) break;
            end
        end
    endtask

    task automatic idle_watch(input int cycles, output int l1, output int l2, output int rises);
        logic prev;
        l1 = 0; l2 = 0; rises = 0; prev = sclk;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (!ssb1) l1++;
            if (!ssb2) l2++;
            if (sclk && !prev) rises++;
            prev = sclk;
        end
    endtask

    initial begin
        logic [7:0] mo;
        logic [7:0] mi;
        int l1, l2, rises, waited, cnt;
        logic prev;

        vecs[0]  = '{2'b10, 2'b01, 1'b1, 8'hA5, 8'h3C};  // write s1: s1=A5
        vecs[1]  = '{2'b00, 2'b01, 1'b0, 8'h00, 8'h00};
        vecs[2]  = '{2'b01, 2'b10, 1'b0, 8'h00, 8'h00};
        vecs[3]  = '{2'b10, 2'b00, 1'b0, 8'h00, 8'h00};
        vecs[4]  = '{2'b11, 2'b11, 1'b0, 8'h00, 8'h00};
        vecs[5]  = '{2'b11, 2'b01, 1'b1, 8'hA5, 8'hA5};  // master unchanged by write
        vecs[6]  = '{2'b11, 2'b10, 1'b1, 8'hA5, 8'hC3};  // m=C3, s2=A5
        vecs[7]  = '{2'b11, 2'b10, 1'b1, 8'hC3, 8'hA5};  // m=A5, s2=C3
        vecs[8]  = '{2'b10, 2'b10, 1'b1, 8'hA5, 8'hC3};  // s2=A5
        vecs[9]  = '{2'b11, 2'b10, 1'b1, 8'hA5, 8'hA5};
        vecs[10] = '{2'b11, 2'b01, 1'b1, 8'hA5, 8'hA5};

        dtf = 2'b00;
        slave = 2'b00;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("reset sclk", 32'(sclk), 32'd0);
        chk("reset mosi", 32'(mosi), 32'd0);
        chk("reset miso", 32'(miso), 32'd0);
        chk("reset ssb1", 32'(ssb1), 32'd1);
        chk("reset ssb2", 32'(ssb2), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            dtf = vecs[i].dtf;
            slave = vecs[i].slave;
            if (vecs[i].act) begin
                measure(0, 2'b00, 1'b1, mo, mi, l1, l2, rises, waited);
                chk($sformatf("v%0d start", i), 32'(waited), 32'd0);
                chk($sformatf("v%0d rises", i), 32'(rises), 32'd8);
                chk($sformatf("v%0d mosi", i), 32'(mo), 32'(vecs[i].exp_mosi));
                chk($sformatf("v%0d miso", i), 32'(mi), 32'(vecs[i].exp_miso));
                chk($sformatf("v%0d ssb1 low", i), 32'(l1),
                    (vecs[i].slave == 2'b01) ? 32'd16 : 32'd0);
                chk($sformatf("v%0d ssb2 low", i), 32'(l2),
                    (vecs[i].slave == 2'b10) ? 32'd16 : 32'd0);
            end else begin
                idle_watch(40, l1, l2, rises);
                chk($sformatf("v%0d idle rises", i), 32'(rises), 32'd0);
                chk($sformatf("v%0d idle ssb1", i), 32'(l1), 32'd0);
                chk($sformatf("v%0d idle ssb2", i), 32'(l2), 32'd0);
                dtf = 2'b00;
            end
        end

        // Select change mid-transfer, then the held request retargets slave 2.
        do_reset();
        dtf = 2'b10;
        slave = 2'b01;
        measure(6, 2'b10, 1'b0, mo, mi, l1, l2, rises, waited);
        chk("sw ssb1 low", 32'(l1), 32'd16);
        chk("sw ssb2 low", 32'(l2), 32'd0);
        chk("sw mosi", 32'(mo), 32'hA5);
        chk("sw miso", 32'(mi), 32'h3C);
        measure(0, 2'b00, 1'b1, mo, mi, l1, l2, rises, waited);
        chk("sw2 gap wait", 32'(waited), 32'd1);
        chk("sw2 ssb1 low", 32'(l1), 32'd0);
        chk("sw2 ssb2 low", 32'(l2), 32'd16);
        chk("sw2 miso", 32'(mi), 32'hC3);
        @(negedge clk);
        dtf = 2'b11;
        slave = 2'b01;
        measure(0, 2'b00, 1'b1, mo, mi, l1, l2, rises, waited);
        chk("sw3 s1 written", 32'(mi), 32'hA5);

        // Abort a write after four rising sclk edges.
        do_reset();
        dtf = 2'b10;
        slave = 2'b01;
        cnt = 0;
        while (cnt < 20) begin
            @(negedge clk);
            if (!ssb1) break;
            cnt++;
        end
        chk("abort start", 32'(cnt < 20), 32'd1);
        dtf = 2'b00;
        rises = 0;
        prev = 1'b0;
        cnt = 0;
        while (rises < 4 && cnt < 40) begin
            if (sclk && !prev) rises++;
            prev = sclk;
            if (rises < 4) @(negedge clk);
            cnt++;
        end
        chk("abort rises", 32'(rises), 32'd4);
        rst = 1'b0;
        #1;
        chk("abort sclk", 32'(sclk), 32'd0);
        chk("abort mosi", 32'(mosi), 32'd0);
        chk("abort miso", 32'(miso), 32'd0);
        chk("abort ssb1", 32'(ssb1), 32'd1);
        chk("abort ssb2", 32'(ssb2), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        dtf = 2'b11;
        slave = 2'b01;
        measure(0, 2'b00, 1'b1, mo, mi, l1, l2, rises, waited);
        chk("post abort miso", 32'(mi), 32'h3C);
        chk("post abort mosi", 32'(mo), 32'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
